// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store engine. It drives the RAM req/ack handshake,
//            aligns and extends load data, and stalls the pipeline while busy.
//            Optional macro MEM_TIMEOUT_EN enables an ACCESS timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_address,
    input  logic [31:0] in_store_data,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic [31:0] ram_data,
    output logic        mem_busy,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_ram_data;
    logic        r_bus_error;

    logic        w_access;
    logic        w_bad_width;
    logic        w_bad_align;
    logic        w_start;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_access = in_valid & (in_mem_read | in_mem_write);

    // A set write bit makes the access a store, even when read is also set.
    always_comb begin
        w_bad_width = 1'b0;
        w_bad_align = 1'b0;
        case (in_funct3)
            3'b000:  w_bad_align = 1'b0;
            3'b001:  w_bad_align = in_address[0];
            3'b010:  w_bad_align = |in_address[1:0];
            3'b100:  w_bad_width = in_mem_write;
            3'b101: begin
                w_bad_width = in_mem_write;
                w_bad_align = in_address[0];
            end
            default: w_bad_width = 1'b1;
        endcase
    end

    assign misaligned = w_access & (w_bad_width | w_bad_align);
    assign w_start    = w_access & ~misaligned & (r_state == c_ST_IDLE);
    assign mem_busy   = w_start | (r_state == c_ST_ACCESS);

    always_comb begin
        w_wdata = in_store_data;
        w_wstrb = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                w_wdata = {4{in_store_data[7:0]}};
                w_wstrb = 4'b0001 << in_address[1:0];
            end
            2'b01: begin
                w_wdata = {2{in_store_data[15:0]}};
                w_wstrb = 4'b0011 << {in_address[1], 1'b0};
            end
            default: begin
                w_wdata = in_store_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte = ram_rdata[7:0];
            2'd1:    w_byte = ram_rdata[15:8];
            2'd2:    w_byte = ram_rdata[23:16];
            default: w_byte = ram_rdata[31:24];
        endcase
        w_half = r_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = ram_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    logic [c_CNT_W-1:0] r_count;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
            r_ram_data  <= 32'd0;
            r_bus_error <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_count     <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_addr   <= {in_address[31:2], 2'b00};
                        r_wdata  <= w_wdata;
                        r_wstrb  <= in_mem_write ? w_wstrb : 4'd0;
                        r_we     <= in_mem_write;
                        r_funct3 <= in_funct3;
                        r_lane   <= in_address[1:0];
                        r_state  <= c_ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
                        r_count  <= '0;
`endif
                    end
                end
                c_ST_ACCESS: begin
                    // An ack in the expiry cycle still completes the access.
                    if (ram_ack) begin
                        if (!r_we) begin
                            r_ram_data <= w_load_data;
                        end
                        r_state <= c_ST_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_count == c_TO_LAST) begin
                        r_ram_data  <= 32'd0;
                        r_bus_error <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_count <= r_count + c_CNT_ONE;
                    end
`endif
                end
                c_ST_DONE: begin
                    r_bus_error <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign ram_req   = (r_state == c_ST_ACCESS);
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_wstrb = r_wstrb;
    assign ram_data  = r_ram_data;
    assign bus_error = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit: a directed vector table,
//            hand-written corner sequences and randomized accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_address;
    logic [31:0] in_store_data;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic        ram_ack;
    logic [31:0] ram_rdata;
    logic [31:0] ram_data;
    logic        mem_busy;
    logic        misaligned;
    logic        bus_error;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_funct3     (in_funct3),
        .in_address    (in_address),
        .in_store_data (in_store_data),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wstrb     (ram_wstrb),
        .ram_ack       (ram_ack),
        .ram_rdata     (ram_rdata),
        .ram_data      (ram_data),
        .mem_busy      (mem_busy),
        .misaligned    (misaligned),
        .bus_error     (bus_error)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          dly;
        logic        exp_mis;
        logic [31:0] exp_data;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] held;
    vec_t        tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes and alignment arithmetic.
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_mis(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        if (!(rd || wr)) return 1'b0;
        if (sz == 8) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        if (f3[2] && sz == 4) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        int          sz   = acc_size(f3);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        logic [31:0] v    = (rdata >> (8 * a[1:0])) & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = acc_size(f3);
        if (sz == 1) return sd[7:0] * 32'h0101_0101;
        if (sz == 2) return sd[15:0] * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int         sz   = acc_size(f3);
        logic [3:0] base = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
        return base << a[1:0];
    endfunction

    function automatic vec_t make_vec(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] sd,
                                      input logic [31:0] rdata, input int dly);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rdata; v.dly = dly;
        v.exp_mis   = model_mis(rd, wr, f3, a);
        v.exp_data  = model_load(f3, a, rdata);
        v.exp_wdata = model_wdata(f3, sd);
        v.exp_strb  = wr ? model_strb(f3, a) : 4'd0;
        return v;
    endfunction

    // Entered and left at posedge+1 with the unit in IDLE.
    task automatic run_txn(input vec_t v);
        logic is_load;
        is_load       = v.rd && !v.wr;
        in_valid      = 1'b1;
        in_mem_read   = v.rd;
        in_mem_write  = v.wr;
        in_funct3     = v.f3;
        in_address    = v.addr;
        in_store_data = v.sd;
        ram_rdata     = $urandom;
        #1;
        chk("misaligned", {31'd0, misaligned}, {31'd0, v.exp_mis});
        if (!(v.rd || v.wr) || v.exp_mis) begin
            chk("busy_noaccess", {31'd0, mem_busy}, 32'd0);
            @(posedge clk); #1;
            chk("req_noaccess", {31'd0, ram_req}, 32'd0);
            chk("data_hold_noaccess", ram_data, held);
        end else begin
            chk("busy_start", {31'd0, mem_busy}, 32'd1);
            for (int i = 0; i <= v.dly; i++) begin
                @(posedge clk); #1;
                if (i == v.dly) begin
                    ram_ack   = 1'b1;
                    ram_rdata = v.rdata;
                end
                #1;
                chk("req_access", {31'd0, ram_req}, 32'd1);
                chk("busy_access", {31'd0, mem_busy}, 32'd1);
                if (i == 0) begin
                    chk("ram_we", {31'd0, ram_we}, {31'd0, v.wr});
                    chk("ram_addr", ram_addr, v.addr & 32'hFFFF_FFFC);
                    chk("ram_wstrb", {28'd0, ram_wstrb}, {28'd0, v.exp_strb});
                    if (v.wr) chk("ram_wdata", ram_wdata, v.exp_wdata);
                end
            end
            @(posedge clk); #1;
            ram_ack   = 1'b0;
            ram_rdata = $urandom;
            #1;
            chk("busy_done", {31'd0, mem_busy}, 32'd0);
            chk("req_done", {31'd0, ram_req}, 32'd0);
            chk("bus_error_done", {31'd0, bus_error}, 32'd0);
            if (is_load) held = v.exp_data;
            chk("ram_data", ram_data, held);
            @(posedge clk); #1;
            chk("req_idle", {31'd0, ram_req}, 32'd0);
        end
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   cnt;

        // rd, wr, f3, addr, store data, rdata, ack delay, mis, load result, wdata, strb
        tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_FFFF, 2, 1'b0, 32'hFFFF_FF80, 32'h0,         4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,         32'hBEEF_1234, 1, 1'b0, 32'h0000_BEEF, 32'h0,         4'b0000};
        tbl[2]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_00AB, 32'h0,         1, 1'b0, 32'h0,         32'hABAB_ABAB, 4'b0010};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,         32'h8001_7FFF, 0, 1'b0, 32'hFFFF_8001, 32'h0,         4'b0000};
        tbl[5]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,         32'h12C3_5678, 0, 1'b0, 32'h0000_00C3, 32'h0,         4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 3'b010, 32'h10C, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, 32'h0,         4'b0000};
        tbl[7]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234_5678, 32'h0,         0, 1'b0, 32'h0,         32'h5678_5678, 4'b1100};
        tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h208, 32'hCAFE_F00D, 32'h0,         2, 1'b0, 32'h0,         32'hCAFE_F00D, 4'b1111};
        tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h20A, 32'h1,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h000, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h000, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        tbl[12] = '{1'b1, 1'b1, 3'b000, 32'h003, 32'h0000_005A, 32'h7777_7777, 0, 1'b0, 32'h0,         32'h5A5A_5A5A, 4'b1000};
        tbl[13] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         0, 1'b1, 32'h0,         32'h0,         4'b0000};
        tbl[14] = '{1'b1, 1'b0, 3'b000, 32'h000, 32'h0,         32'h0000_007F, 1, 1'b0, 32'h0000_007F, 32'h0,         4'b0000};

        reset = 1'b1; in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_funct3 = 3'd0; in_address = 32'd0; in_store_data = 32'd0;
        ram_ack = 1'b0; ram_rdata = 32'd0; held = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_req", {31'd0, ram_req}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_addr", ram_addr, 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, ram_wstrb}, 32'd0);
        chk("rst_data", ram_data, 32'd0);
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);

        for (int i = 0; i < 15; i++) run_txn(tbl[i]);

        // Back-to-back loads: the second may only start after DONE.
        run_txn(make_vec(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h1357_9BDF, 0));
        run_txn(make_vec(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h2468_ACE0, 0));

        // An ack while idle must not disturb anything.
        ram_ack = 1'b1; ram_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        #1;
        chk("idle_ack_data", ram_data, held);
        chk("idle_ack_req", {31'd0, ram_req}, 32'd0);

        // Reset in ACCESS, with the ack arriving one cycle late.
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_address = 32'h40;
        @(posedge clk); #1;
        chk("pre_reset_req", {31'd0, ram_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0;
        ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
        #1;
        chk("reset_req", {31'd0, ram_req}, 32'd0);
        chk("reset_data", ram_data, 32'd0);
        chk("reset_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        ram_ack = 1'b0;
        #1;
        chk("late_ack_data", ram_data, 32'd0);
        chk("late_ack_req", {31'd0, ram_req}, 32'd0);
        held = 32'd0;

`ifdef MEM_TIMEOUT_EN
        run_txn(make_vec(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'hA5A5_5A5A, 0));
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'b010; in_address = 32'h80;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (!ram_req) break;
            cnt++;
        end
        chk("timeout_cycles", cnt, 32'd4);
        chk("timeout_bus_error", {31'd0, bus_error}, 32'd1);
        chk("timeout_data", ram_data, 32'd0);
        chk("timeout_busy", {31'd0, mem_busy}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_read = 1'b0;
        #1;
        chk("timeout_clear", {31'd0, bus_error}, 32'd0);
        chk("timeout_idle_req", {31'd0, ram_req}, 32'd0);
        held = 32'd0;
`else
        cnt = 0;
`endif

        for (int i = 0; i < 200; i++) begin
            v = make_vec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                         int'($urandom_range(0, 3)));
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
